// File: rtl/write_sm.sv
// -----------------------------------------------------------------------------
// write_sm
//   Transmit side of the handshake/read/done word transfer. A local producer
//   pushes words into a small FIFO. The state machine presents the words one at
//   a time on tx_data with handshake high, waits for a read pulse, and then
//   holds handshake low for GAP cycles before it presents the next word.
//
//   Transfer protocol: handshake = 1 means tx_data holds a valid word and the
//   word is waiting for the receiver. A word is consumed on the rising edge
//   where read = 1 while handshake = 1. tx_data is stable for as long as
//   handshake stays high. If read does not arrive within TIMEOUT cycles, the
//   word is dropped instead. A read that arrives while handshake is low is a
//   protocol error.
//
// Ports
//   clk, reset       system clock; synchronous active-high reset
//   wr_en, wr_data   producer write strobe and word (ignored while full)
//   full, empty      FIFO holds DEPTH / 0 words
//   level            FIFO occupancy, not counting the word in flight
//   read             receiver acknowledge pulse
//   handshake        tx_data valid, awaiting read
//   tx_data          word in flight
//   sent             1-cycle pulse per acknowledged word
//   timeout_err      1-cycle pulse per word dropped on timeout
//   proto_err        sticky: read seen outside PRESENT
//   state_o          current FSM state (debug observation)
// -----------------------------------------------------------------------------
module write_sm #(
   parameter int DATA_W  = 16,
   parameter int DEPTH   = 4,
   parameter int GAP     = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_en,
   input  logic [DATA_W-1:0]         wr_data,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    level,
   input  logic                      read,
   output logic                      handshake,
   output logic [DATA_W-1:0]         tx_data,
   output logic                      sent,
   output logic                      timeout_err,
   output logic                      proto_err,
   output logic [1:0]                state_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = $clog2(GAP + 1);
   // With TIMEOUT = 0 the counter is never used; keep it 1 bit wide.
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PRESENT = 2'd1,
      S_GAP     = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]       count_q;
   logic [GW-1:0]       gap_q, gap_d;
   logic [TW-1:0]       tcnt_q, tcnt_d;
   logic                hs_q, hs_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic                sent_q, sent_d;
   logic                terr_q, terr_d;
   logic                perr_q, perr_d;
   logic                push, pop;

   assign full        = (count_q == CW'(DEPTH));
   assign empty       = (count_q == '0);
   assign level       = count_q;
   assign handshake   = hs_q;
   assign tx_data     = tx_q;
   assign sent        = sent_q;
   assign timeout_err = terr_q;
   assign proto_err   = perr_q;
   assign state_o     = state_q;

   always_comb begin
      // full is taken from the registered count, so a write into a full FIFO
      // is dropped even when a pop happens on the same edge.
      push    = wr_en && !full;
      pop     = 1'b0;
      state_d = state_q;
      gap_d   = gap_q;
      tcnt_d  = tcnt_q;
      hs_d    = hs_q;
      tx_d    = tx_q;
      sent_d  = 1'b0;
      terr_d  = 1'b0;
      perr_d  = perr_q | (read && (state_q != S_PRESENT));

      case (state_q)
         S_IDLE: begin
            if (!empty) pop = 1'b1;
         end
         S_PRESENT: begin
            // read takes priority over a timeout that expires on the same edge.
            if (read) begin
               hs_d    = 1'b0;
               sent_d  = 1'b1;
               gap_d   = GW'(GAP);
               state_d = S_GAP;
            end else if (TIMEOUT != 0) begin
               tcnt_d = tcnt_q + TW'(1);
               if (tcnt_d == TW'(TIMEOUT)) begin
                  hs_d    = 1'b0;
                  terr_d  = 1'b1;
                  gap_d   = GW'(GAP);
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            gap_d = gap_q - GW'(1);
            // On the last gap cycle, go straight to the next word when one is
            // queued. This keeps the low time between words at exactly GAP.
            if (gap_q <= GW'(1)) begin
               if (!empty) pop = 1'b1;
               else        state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (pop) begin
         tx_d    = mem_q[rd_ptr_q];
         hs_d    = 1'b1;
         tcnt_d  = '0;
         state_d = S_PRESENT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         gap_q    <= '0;
         tcnt_q   <= '0;
         hs_q     <= 1'b0;
         tx_q     <= '0;
         sent_q   <= 1'b0;
         terr_q   <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_q + AW'(push);
         rd_ptr_q <= rd_ptr_q + AW'(pop);
         count_q  <= count_q + CW'(push) - CW'(pop);
         gap_q    <= gap_d;
         tcnt_q   <= tcnt_d;
         hs_q     <= hs_d;
         tx_q     <= tx_d;
         sent_q   <= sent_d;
         terr_q   <= terr_d;
         perr_q   <= perr_d;
      end
   end

   // Storage is not reset; the pointers and the count define which entries hold data.
   always_ff @(posedge clk) begin
      if (!reset && push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: tb/tb_write_sm.sv
// -----------------------------------------------------------------------------
// tb_write_sm
//   Randomised and directed stimulus for write_sm. The behavioural model holds
//   the FIFO as a queue and the transfer as "presenting / gap cycles left".
//   Each word the model presents is pushed to exp_q. Each acknowledged or
//   dropped word pushes its outcome to res_q. A negedge monitor pops both
//   queues when the DUT raises handshake or pulses sent/timeout_err.
// -----------------------------------------------------------------------------
module tb_write_sm;

   localparam int DATA_W  = 16;
   localparam int DEPTH   = 4;
   localparam int GAP     = 2;
   localparam int TIMEOUT = 8;

   // ---------------- clock / reset ----------------
   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              wr_en = 1'b0;
   logic [15:0]       wr_data = '0;
   logic              read = 1'b0;
   logic              full, empty, handshake, sent, timeout_err, proto_err;
   logic [2:0]        level;
   logic [15:0]       tx_data;
   logic [1:0]        state_o;

   always #5 clk = ~clk;

   write_sm #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .GAP    (GAP),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .full       (full),
      .empty      (empty),
      .level      (level),
      .read       (read),
      .handshake  (handshake),
      .tx_data    (tx_data),
      .sent       (sent),
      .timeout_err(timeout_err),
      .proto_err  (proto_err),
      .state_o    (state_o)
   );

   // ---------------- scoreboard ----------------
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_q[$];
   logic        res_q[$];   // 1 = sent, 0 = timed out

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [15:0] mq[$];          // words waiting in the FIFO
   bit          m_present = 0;  // a word is on offer
   int          m_gap_left = 0; // low cycles still owed after a word
   int          m_age = 0;      // cycles the current word has waited
   logic [15:0] m_word = '0;
   bit          m_sent = 0, m_tout = 0, m_proto = 0;
   bit          m_accept, m_take;

   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
         m_present  = 0;
         m_gap_left = 0;
         m_age      = 0;
         m_word     = '0;
         m_sent     = 0;
         m_tout     = 0;
         m_proto    = 0;
      end else begin
         m_sent   = 0;
         m_tout   = 0;
         m_take   = 0;
         m_accept = wr_en && (mq.size() < DEPTH);
         if (read && !m_present) m_proto = 1;
         if (m_present) begin
            if (read) begin
               m_present  = 0;
               m_sent     = 1;
               m_gap_left = GAP;
               res_q.push_back(1'b1);
            end else begin
               m_age++;
               if (TIMEOUT != 0 && m_age == TIMEOUT) begin
                  m_present  = 0;
                  m_tout     = 1;
                  m_gap_left = GAP;
                  res_q.push_back(1'b0);
               end
            end
         end else if (m_gap_left > 0) begin
            m_gap_left--;
            m_take = (m_gap_left == 0) && (mq.size() > 0);
         end else begin
            m_take = (mq.size() > 0);
         end
         if (m_take) begin
            m_word    = mq.pop_front();
            m_present = 1;
            m_age     = 0;
            exp_q.push_back(m_word);
         end
         if (m_accept) mq.push_back(wr_data);
      end
   end

   // ---------------- monitor ----------------
   logic        hs_prev = 1'b0;
   logic [15:0] w_exp;
   logic        r_exp;

   always @(negedge clk) begin
      chk("handshake", handshake, m_present);
      chk("level", level, mq.size());
      chk("full", full, mq.size() == DEPTH);
      chk("empty", empty, mq.size() == 0);
      chk("tx_data", tx_data, m_word);
      chk("sent", sent, m_sent);
      chk("timeout_err", timeout_err, m_tout);
      chk("proto_err", proto_err, m_proto);
      if (handshake === 1'b1 && hs_prev !== 1'b1) begin
         chk("present_queued", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            w_exp = exp_q.pop_front();
            chk("present_word", tx_data, w_exp);
         end
      end
      if (sent === 1'b1 || timeout_err === 1'b1) begin
         chk("one_outcome", sent & timeout_err, 0);
         chk("outcome_queued", res_q.size() > 0, 1);
         if (res_q.size() > 0) begin
            r_exp = res_q.pop_front();
            chk("outcome_kind", sent, r_exp);
         end
      end
      hs_prev = handshake;
   end

   // ---------------- driver ----------------
   int age = 0;
   int cur_delay = 3;
   int fixed_delay = 0;   // 0 = random read latency 1..10
   bit spur_en = 0;

   // Drive one cycle. The read latency is counted in cycles since handshake rose.
   task automatic cycle(input logic w, input logic [15:0] d, input logic rf);
      @(negedge clk);
      reset   = 1'b0;
      wr_en   = w;
      wr_data = d;
      if (handshake === 1'b1) begin
         age++;
         read = (age == cur_delay) || rf;
      end else begin
         age       = 0;
         cur_delay = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 10));
         read      = rf || (spur_en && ($urandom_range(0, 7) == 0));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 16'h0000, 1'b0);
   endtask

   task automatic do_reset(input int n);
      repeat (n) begin
         @(negedge clk);
         reset = 1'b1;
         wr_en = 1'b0;
         read  = 1'b0;
      end
   endtask

   initial begin
      do_reset(3);

      // Single word, read three cycles after presentation.
      fixed_delay = 3;
      cycle(1'b1, 16'h1234, 1'b0);
      idle(12);

      // Burst past capacity; the extra words are dropped while full.
      for (int i = 0; i < 7; i++) cycle(1'b1, 16'(16'h00A0 + i), 1'b0);
      idle(50);

      // Never read: both words time out, second follows after the gap.
      fixed_delay = 20;
      cycle(1'b1, 16'h5555, 1'b0);
      cycle(1'b1, 16'h6666, 1'b0);
      idle(40);

      // Reads while idle and during gaps raise the sticky error.
      fixed_delay = 3;
      cycle(1'b0, 16'h0000, 1'b1);
      idle(2);
      cycle(1'b0, 16'h0000, 1'b1);
      cycle(1'b1, 16'h7777, 1'b0);
      fixed_delay = 0;
      spur_en = 1;
      repeat (120) cycle(1'($urandom_range(0, 99) < 40), 16'($urandom), 1'b0);
      spur_en = 0;
      do_reset(1);

      // Reset while presenting with two words queued.
      fixed_delay = 30;
      cycle(1'b1, 16'h1111, 1'b0);
      cycle(1'b1, 16'h2222, 1'b0);
      cycle(1'b1, 16'h3333, 1'b0);
      idle(3);
      do_reset(1);
      fixed_delay = 3;
      cycle(1'b1, 16'hBEEF, 1'b0);
      idle(15);

      // Random traffic with random read latency, including timeouts.
      fixed_delay = 0;
      repeat (600) cycle(1'($urandom_range(0, 99) < 45), 16'($urandom), 1'b0);

      // Drain, then every presented word and outcome must be accounted for.
      idle(80);
      @(negedge clk);
      #1;
      chk("exp_q_drained", exp_q.size(), 0);
      chk("res_q_drained", res_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
